// File: rtl/tile_scroller.sv
// Piano Tiles motion and game-state stage: four falling tiles, lane hit detection, score, game over.
// Build option: define TILE_SCROLLER_STRICT_MISS_EN to end the game on a press with no tile in the hit zone.
module tile_scroller #(
    parameter int TILE_HALF = 30,
    parameter int SPEED     = 2,
    parameter int HIT_TOP   = 360,
    parameter int BOTTOM_Y  = 450,
    parameter int SPAWN_Y   = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic [3:0]  lane_key,
    output logic [9:0]  BallX,
    output logic [9:0]  BallY,
    output logic [9:0]  BallX2,
    output logic [9:0]  BallY2,
    output logic [9:0]  BallX3,
    output logic [9:0]  BallY3,
    output logic [9:0]  BallX4,
    output logic [9:0]  BallY4,
    output logic [9:0]  Ball_size,
    output logic [15:0] score,
    output logic        playing,
    output logic        game_over
);

`ifdef TILE_SCROLLER_STRICT_MISS_EN
    localparam bit STRICT_MISS = 1'b1;
`else
    localparam bit STRICT_MISS = 1'b0;
`endif

    localparam logic [9:0] HIT_TOP_Y = 10'(HIT_TOP);
    localparam logic [9:0] BOTTOM_LIM = 10'(BOTTOM_Y);
    localparam logic [9:0] SPAWN_POS = 10'(SPAWN_Y);
    localparam logic [9:0] SPEED_Y = 10'(SPEED);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

    state_t      state, state_next;
    logic [2:0]  frame_sync, start_sync;
    logic [3:0]  key_s1, key_s2, key_s3;
    logic        tick, go;
    logic [3:0]  press;
    logic [7:0]  lfsr;
    logic [1:0]  lane [4];
    logic [9:0]  tile_y [4];
    logic [3:0]  hit;
    logic        miss_press;
    logic        overflow;
    logic [2:0]  hit_count;
    logic [16:0] score_sum;

    // Two synchroniser flops, third flop remembers the previous level for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_sync <= '0;
            start_sync <= '0;
            key_s1     <= '0;
            key_s2     <= '0;
            key_s3     <= '0;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
            start_sync <= {start_sync[1:0], start};
            key_s1     <= lane_key;
            key_s2     <= key_s1;
            key_s3     <= key_s2;
        end
    end

    assign tick  = frame_sync[1] & ~frame_sync[2];
    assign go    = start_sync[1] & ~start_sync[2];
    assign press = key_s2 & ~key_s3;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Per lane, the lowest-on-screen candidate wins; strict '>' keeps the lowest index on ties.
    always_comb begin
        logic [1:0] best;
        logic       found;
        hit        = '0;
        miss_press = 1'b0;
        best       = 2'd0;
        found      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            best  = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (lane[i] == 2'(k) && tile_y[i] >= HIT_TOP_Y && tile_y[i] <= BOTTOM_LIM &&
                    (!found || tile_y[i] > tile_y[best])) begin
                    found = 1'b1;
                    best  = 2'(i);
                end
            end
            if (press[k]) begin
                if (found) hit[best] = 1'b1;
                else       miss_press = 1'b1;
            end
        end
    end

    always_comb begin
        overflow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tile_y[i] > BOTTOM_LIM) overflow = 1'b1;
        end
    end

    assign hit_count = {2'b0, hit[0]} + {2'b0, hit[1]} + {2'b0, hit[2]} + {2'b0, hit[3]};
    assign score_sum = {1'b0, score} + 17'(hit_count);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // A committed overflow is seen one cycle later, so the miss lands in OVER the cycle after the move.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (go) state_next = PLAY;
            PLAY: begin
                if (overflow)                      state_next = OVER;
                else if (STRICT_MISS && miss_press) state_next = OVER;
            end
            OVER: if (go) state_next = PLAY;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        playing   = (state == PLAY);
        game_over = (state == OVER);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                lane[i]   <= 2'(i);
                tile_y[i] <= 10'(30 + 120 * i);
            end
            score <= '0;
        end else if (go && (state == IDLE || state == OVER)) begin
            for (int i = 0; i < 4; i++) begin
                lane[i]   <= 2'(i);
                tile_y[i] <= 10'(30 + 120 * i);
            end
            score <= '0;
        end else if (state == PLAY && !overflow) begin
            for (int i = 0; i < 4; i++) begin
                if (hit[i]) begin
                    tile_y[i] <= SPAWN_POS;
                    lane[i]   <= lfsr[2*i +: 2];
                end else if (tick) begin
                    tile_y[i] <= tile_y[i] + SPEED_Y;
                end
            end
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    function automatic logic [9:0] tile_x(input logic [1:0] l);
        return 10'd80 + 10'd160 * 10'(l);
    endfunction

    assign BallX     = tile_x(lane[0]);
    assign BallX2    = tile_x(lane[1]);
    assign BallX3    = tile_x(lane[2]);
    assign BallX4    = tile_x(lane[3]);
    assign BallY     = tile_y[0];
    assign BallY2    = tile_y[1];
    assign BallY3    = tile_y[2];
    assign BallY4    = tile_y[3];
    assign Ball_size = 10'(TILE_HALF);

endmodule

// File: tb/tb_tile_scroller.sv
// Bench for tile_scroller: directed scenarios plus randomized play checked against a game-rule model.
// Input conditioning is modelled as "event seen at the third edge after an input rises".
module tb_tile_scroller;

`ifdef TILE_SCROLLER_STRICT_MISS_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_OVER = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  lane_key = 4'd0;
    logic [9:0]  BallX, BallY, BallX2, BallY2, BallX3, BallY3, BallX4, BallY4, Ball_size;
    logic [15:0] score;
    logic        playing, game_over;

    int checks = 0;
    int errors = 0;

    // Behavioural game model
    int         m_state;
    int         m_lane [4];
    int         m_y [4];
    int         m_score;
    logic [7:0] m_lfsr;
    logic [2:0] h_frame, h_start;
    logic [3:0] h_key0, h_key1, h_key2;

    logic [97:0] dut_vec;
    assign dut_vec = {BallX, BallY, BallX2, BallY2, BallX3, BallY3, BallX4, BallY4, score, playing, game_over};

    tile_scroller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .lane_key(lane_key),
        .BallX(BallX), .BallY(BallY), .BallX2(BallX2), .BallY2(BallY2),
        .BallX3(BallX3), .BallY3(BallY3), .BallX4(BallX4), .BallY4(BallY4),
        .Ball_size(Ball_size), .score(score), .playing(playing), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic void model_new_game();
        for (int i = 0; i < 4; i++) begin
            m_lane[i] = i;
            m_y[i]    = 30 + 120 * i;
        end
        m_score = 0;
    endfunction

    function automatic void model_reset();
        model_new_game();
        m_state = S_IDLE;
        m_lfsr  = 8'hA5;
        h_frame = '0;
        h_start = '0;
        h_key0  = '0;
        h_key1  = '0;
        h_key2  = '0;
    endfunction

    function automatic void model_edge();
        logic       ev_tick, ev_go;
        logic [3:0] ev_press;
        bit         is_hit [4];
        int         hits, best;
        bit         strict_miss, over_now;
        ev_tick  = h_frame[1] & ~h_frame[2];
        ev_go    = h_start[1] & ~h_start[2];
        ev_press = h_key1 & ~h_key2;
        if (m_state != S_PLAY) begin
            if (ev_go) begin
                model_new_game();
                m_state = S_PLAY;
            end
        end else begin
            over_now = 0;
            for (int i = 0; i < 4; i++) if (m_y[i] > 450) over_now = 1;
            if (over_now) begin
                m_state = S_OVER;
            end else begin
                hits = 0;
                strict_miss = 0;
                for (int i = 0; i < 4; i++) is_hit[i] = 0;
                for (int k = 0; k < 4; k++) begin
                    if (ev_press[k]) begin
                        best = -1;
                        for (int i = 0; i < 4; i++)
                            if (m_lane[i] == k && m_y[i] >= 360 && m_y[i] <= 450 &&
                                (best < 0 || m_y[i] > m_y[best])) best = i;
                        if (best >= 0) begin
                            is_hit[best] = 1;
                            hits++;
                        end else strict_miss = 1;
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (is_hit[i]) begin
                        m_y[i]    = 30;
                        m_lane[i] = int'((m_lfsr >> (2 * i)) & 8'h03);
                    end else if (ev_tick) m_y[i] = m_y[i] + 2;
                end
                m_score = (m_score + hits > 65535) ? 65535 : m_score + hits;
                if (STRICT && strict_miss) m_state = S_OVER;
            end
        end
        m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        h_frame = {h_frame[1:0], frame_clk};
        h_start = {h_start[1:0], start};
        h_key2  = h_key1;
        h_key1  = h_key0;
        h_key0  = lane_key;
    endfunction

    function automatic logic [97:0] model_vec();
        return {10'(80 + 160 * m_lane[0]), 10'(m_y[0]), 10'(80 + 160 * m_lane[1]), 10'(m_y[1]),
                10'(80 + 160 * m_lane[2]), 10'(m_y[2]), 10'(80 + 160 * m_lane[3]), 10'(m_y[3]),
                16'(m_score), m_state == S_PLAY, m_state == S_OVER};
    endfunction

    // Clock/reset and driver tasks; inputs only change 1 time unit after a rising edge.
    task automatic cyc();
        @(posedge Clk);
        if (!Reset) model_edge();
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        frame_clk = 1'b0;
        start = 1'b0;
        lane_key = 4'd0;
        cyc();
        cyc();
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic restart();
        start = 1'b0;
        repeat (3) cyc();
        start = 1'b1;
        repeat (5) cyc();
    endtask

    task automatic fresh_game();
        do_reset();
        restart();
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        repeat (3) cyc();
        frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic press_keys(input logic [3:0] keys);
        lane_key = keys;
        repeat (3) cyc();
        lane_key = 4'd0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (playing !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: playing=%b game_over=%b expected 0 0", playing, game_over);
        end
        checks++;
        if (score !== 16'd0 || Ball_size !== 10'd30) begin
            errors++;
            $display("FAIL reset_score_size: score=%0d size=%0d expected 0 30", score, Ball_size);
        end
        checks++;
        if ({BallY, BallY2, BallY3, BallY4} !== {10'd30, 10'd150, 10'd270, 10'd390}) begin
            errors++;
            $display("FAIL reset_y: %0d %0d %0d %0d expected 30 150 270 390", BallY, BallY2, BallY3, BallY4);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        repeat (5) cyc();
        checks++;
        if (playing !== 1'b1 || game_over !== 1'b0 || score !== 16'd0) begin
            errors++;
            $display("FAIL start_flags: playing=%b over=%b score=%0d expected 1 0 0", playing, game_over, score);
        end
        checks++;
        if ({BallX, BallX2, BallX3, BallX4} !== {10'd80, 10'd240, 10'd400, 10'd560}) begin
            errors++;
            $display("FAIL start_x: %0d %0d %0d %0d expected 80 240 400 560", BallX, BallX2, BallX3, BallX4);
        end
        checks++;
        if ({BallY, BallY2, BallY3, BallY4} !== {10'd30, 10'd150, 10'd270, 10'd390}) begin
            errors++;
            $display("FAIL start_y: %0d %0d %0d %0d expected 30 150 270 390", BallY, BallY2, BallY3, BallY4);
        end
    endtask

    task automatic test_fall_to_miss();
        repeat (30) frame_pulse();
        frame_clk = 1'b1;
        repeat (3) cyc();
        checks++;
        if (BallY4 !== 10'd452 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL miss_y: tile3 y=%0d over=%b expected 452 0", BallY4, game_over);
        end
        cyc();
        checks++;
        if (game_over !== 1'b1 || playing !== 1'b0) begin
            errors++;
            $display("FAIL miss_over: over=%b playing=%b expected 1 0", game_over, playing);
        end
        frame_clk = 1'b0;
        repeat (2) cyc();
        repeat (3) frame_pulse();
        checks++;
        if ({BallY, BallY2, BallY3, BallY4} !== {10'd92, 10'd212, 10'd332, 10'd452} || game_over !== 1'b1) begin
            errors++;
            $display("FAIL miss_frozen: %0d %0d %0d %0d over=%b expected 92 212 332 452 1",
                     BallY, BallY2, BallY3, BallY4, game_over);
        end
    endtask

    task automatic test_hit_lane3();
        int exp_lane;
        restart();
        checks++;
        if (playing !== 1'b1 || BallY4 !== 10'd390) begin
            errors++;
            $display("FAIL restart: playing=%b tile3 y=%0d expected 1 390", playing, BallY4);
        end
        lane_key = 4'b1000;
        repeat (2) cyc();
        exp_lane = int'(m_lfsr[7:6]);
        cyc();
        checks++;
        if (BallY4 !== 10'd30 || BallX4 !== 10'(80 + 160 * exp_lane) || score !== 16'd1) begin
            errors++;
            $display("FAIL hit_lane3: y=%0d x=%0d score=%0d expected 30 %0d 1", BallY4, BallX4, score, 80 + 160 * exp_lane);
        end
        checks++;
        if ({BallY, BallY2, BallY3} !== {10'd30, 10'd150, 10'd270} || {BallX, BallX2, BallX3} !== {10'd80, 10'd240, 10'd400}) begin
            errors++;
            $display("FAIL hit_others: y=%0d %0d %0d x=%0d %0d %0d expected 30 150 270 / 80 240 400",
                     BallY, BallY2, BallY3, BallX, BallX2, BallX3);
        end
        lane_key = 4'd0;
        repeat (3) cyc();
    endtask

    task automatic test_press_and_tick();
        fresh_game();
        lane_key = 4'b1000;
        frame_clk = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({BallY, BallY2, BallY3, BallY4} !== {10'd32, 10'd152, 10'd272, 10'd30} || score !== 16'd1) begin
            errors++;
            $display("FAIL press_tick: %0d %0d %0d %0d score=%0d expected 32 152 272 30 1",
                     BallY, BallY2, BallY3, BallY4, score);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL press_tick_model: dut=%h model=%h", dut_vec, model_vec());
        end
        lane_key = 4'd0;
        frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_no_candidate();
        fresh_game();
        press_keys(4'b0001);
        checks++;
        if (STRICT) begin
            if (game_over !== 1'b1) begin
                errors++;
                $display("FAIL no_cand_strict: over=%b expected 1", game_over);
            end
        end else begin
            if (game_over !== 1'b0 || score !== 16'd0 || {BallY, BallY2, BallY3, BallY4} !== {10'd30, 10'd150, 10'd270, 10'd390}) begin
                errors++;
                $display("FAIL no_cand_ignore: over=%b score=%0d y=%0d %0d %0d %0d expected 0 0 30 150 270 390",
                         game_over, score, BallY, BallY2, BallY3, BallY4);
            end
        end
    endtask

    task automatic test_reset_mid_game();
        logic [3:0] keys;
        int exp_lane;
        fresh_game();
        for (int n = 0; n < 400 && m_score < 5 && m_state == S_PLAY; n++) begin
            keys = 4'd0;
            for (int i = 0; i < 4; i++)
                if (m_y[i] >= 360 && m_y[i] <= 450) keys[m_lane[i]] = 1'b1;
            if (keys != 4'd0) press_keys(keys);
            else frame_pulse();
        end
        checks++;
        if (score !== 16'd5 || playing !== 1'b1) begin
            errors++;
            $display("FAIL score_five: score=%0d playing=%b expected 5 1", score, playing);
        end
        start = 1'b0;
        #3 Reset = 1'b1;
        #1;
        checks++;
        if (playing !== 1'b0 || game_over !== 1'b0 || score !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: playing=%b over=%b score=%0d expected 0 0 0", playing, game_over, score);
        end
        checks++;
        if ({BallY, BallY2, BallY3, BallY4} !== {10'd30, 10'd150, 10'd270, 10'd390} ||
            {BallX, BallX2, BallX3, BallX4} !== {10'd80, 10'd240, 10'd400, 10'd560}) begin
            errors++;
            $display("FAIL async_reset_tiles: y=%0d %0d %0d %0d x=%0d %0d %0d %0d", BallY, BallY2, BallY3, BallY4,
                     BallX, BallX2, BallX3, BallX4);
        end
        cyc();
        cyc();
        Reset = 1'b0;
        model_reset();
        restart();
        lane_key = 4'b1000;
        repeat (2) cyc();
        exp_lane = int'(m_lfsr[7:6]);
        cyc();
        checks++;
        if (BallX4 !== 10'(80 + 160 * exp_lane) || BallY4 !== 10'd30) begin
            errors++;
            $display("FAIL lfsr_after_reset: x=%0d y=%0d expected %0d 30", BallX4, BallY4, 80 + 160 * exp_lane);
        end
        lane_key = 4'd0;
        repeat (3) cyc();
    endtask

    task automatic test_random();
        int shown = 0;
        fresh_game();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) lane_key[b] = ~lane_key[b];
            if ($urandom_range(0, 29) == 0) start = ~start;
            cyc();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: dut=%h model=%h", n, dut_vec, model_vec());
                end
            end
        end
        lane_key = 4'd0;
        frame_clk = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_fall_to_miss();
        test_hit_lane3();
        test_press_and_tick();
        test_no_candidate();
        test_reset_mid_game();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
